// File: rtl/zx_pkg.sv
// Shared types and constants for the ZX80/ZX81 tape loader.
// The patch image replaces the ROM LOAD routine while a tape is copied into RAM:
//   AF        XOR A          (clears carry)
//   p1        NOP / SCF      (SCF once the copy is complete)
//   30 FD     JR NC,-3       (spin until p1 becomes SCF)
//   C3 lo 02  JP 02lo        (resume in ROM past the LOAD routine)
package zx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  localparam logic [7:0] OpXorA  = 8'hAF;
  localparam logic [7:0] OpNop   = 8'h00;
  localparam logic [7:0] OpScf   = 8'h37;
  localparam logic [7:0] OpJrNc  = 8'h30;
  localparam logic [7:0] OpJrOff = 8'hFD;
  localparam logic [7:0] OpJp    = 8'hC3;

  localparam logic [7:0] RetLo81 = 8'h07;
  localparam logic [7:0] RetLo80 = 8'h03;
  localparam logic [7:0] RetHi   = 8'h02;

  // .o images load from the start of RAM, .p images skip the system variables before 4009
  localparam logic [15:0] BaseO = 16'h4000;
  localparam logic [15:0] BaseP = 16'h4009;

  // Byte of the patch image at the given offset from the trap address
  function automatic logic [7:0] patch_byte(input logic [15:0] offset,
                                            input logic [7:0]  p1,
                                            input logic        zx81);
    logic [7:0] b;
    case (offset)
      16'd0:   b = OpXorA;
      16'd1:   b = p1;
      16'd2:   b = OpJrNc;
      16'd3:   b = OpJrOff;
      16'd4:   b = OpJp;
      16'd5:   b = zx81 ? RetLo81 : RetLo80;
      16'd6:   b = RetHi;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/zx_tape_loader_if.sv
// Main-RAM write port driven by the tape loader.
interface zx_tape_loader_if;
  logic [15:0] ram_a;
  logic [7:0]  ram_din;
  logic        ram_we;

  modport master (output ram_a, output ram_din, output ram_we);
  modport slave  (input ram_a, input ram_din, input ram_we);
endinterface

// File: rtl/zx_tape_buf.sv
// Tape image buffer: one write port, one synchronous read port (latency 1).
// Contents are not reset so an image survives a CPU reset.
module zx_tape_buf #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Write download bytes; register the read data every cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/zx_tape_loader.sv
// ZX80/ZX81 fast tape loader.
// A downloaded tape image is held in a buffer. When the CPU fetches the ROM LOAD
// trap address, fetches inside the trap window are served from a small patch that
// spins until the image has been copied into main RAM, then returns to ROM.
// Optional build macro ZX_TAPE_CHECKSUM_EN adds output tape_sum, the modulo-256 sum
// of the bytes written to RAM since the last entry into the load state.
module zx_tape_loader
  import zx_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter logic [15:0] TRAP81 = 16'h0347,
  parameter logic [15:0] END81  = 16'h03C3,
  parameter logic [15:0] TRAP80 = 16'h0207,
  parameter logic [15:0] END80  = 16'h024D
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce_cpu_p,
  input  logic                  zx81,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic [7:0]            ioctl_index,
  input  logic [15:0]           addr,
  input  logic                  nM1,
  zx_tape_loader_if.master      ram,
  output logic [7:0]            patch_dout,
  output logic                  active,
  output logic                  tape_ready
`ifdef ZX_TAPE_CHECKSUM_EN
  ,
  output logic [7:0]            tape_sum
`endif
);

  localparam int unsigned LenW = ADDR_W + 1;
  localparam logic [25:0] Depth = 26'd1 << ADDR_W;

  // Download side
  logic            dl_q;
  logic            wrote_q;
  logic [24:0]     last_q;
  logic [LenW-1:0] tape_len_q;
  logic [15:0]     base_q;
  logic            tape_ready_q;

  logic            index_ok;
  logic            in_range;
  logic            buf_we;
  logic            dl_rise;
  logic            dl_fall;
  logic [25:0]     last_p1;
  logic [25:0]     len_cap;
  logic [LenW-1:0] new_len;

  // Copy side
  state_e          state_q, state_d;
  logic [LenW-1:0] rd_ptr_q, rd_ptr_d;
  logic            rd_ok_q, rd_ok_d;
  logic [7:0]      p1_q, p1_d;
  logic            nm1_q;
  logic            m1_fall;
  logic            xfer;
  logic [15:0]     trap;
  logic [15:0]     win_end;
  logic            out_of_window;
  logic [7:0]      buf_rdata;

  logic [15:0]     ram_a_q;
  logic [7:0]      ram_din_q;
  logic            ram_we_q;

  assign index_ok = ioctl_index != 8'h00;
  assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
  assign buf_we   = ioctl_wr & index_ok & in_range;
  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign m1_fall  = nm1_q & ~nM1;

  // Length is one past the last written address, clamped to the buffer depth
  assign last_p1  = {1'b0, last_q} + 26'd1;
  assign len_cap  = (last_p1 > Depth) ? Depth : last_p1;
  assign new_len  = wrote_q ? LenW'(len_cap) : '0;

  assign trap          = zx81 ? TRAP81 : TRAP80;
  assign win_end       = zx81 ? END81 : END80;
  assign out_of_window = (addr < trap) || (addr >= win_end);

  zx_tape_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk_sys),
    .we    (buf_we),
    .waddr (ioctl_addr[ADDR_W-1:0]),
    .wdata (ioctl_dout),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (buf_rdata)
  );

  // Track the download and latch image length, base and ready flag when it ends
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q         <= 1'b0;
      wrote_q      <= 1'b0;
      last_q       <= '0;
      tape_len_q   <= '0;
      base_q       <= BaseO;
      tape_ready_q <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_rise) begin
        wrote_q      <= 1'b0;
        tape_ready_q <= 1'b0;
      end else if (dl_fall && index_ok) begin
        tape_len_q   <= new_len;
        base_q       <= (ioctl_index[7:6] != 2'b00) ? BaseP : BaseO;
        tape_ready_q <= new_len != '0;
      end
      if (ioctl_wr && index_ok) begin
        wrote_q <= 1'b1;
        last_q  <= ioctl_addr;
      end
    end
  end

  // Loader state, read pointer, patch byte and M1 edge detector
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      rd_ok_q  <= 1'b0;
      p1_q     <= OpNop;
      nm1_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      rd_ok_q  <= rd_ok_d;
      p1_q     <= p1_d;
      nm1_q    <= nM1;
    end
  end

  // Next-state: trap entry, one byte per CPU enable, completion and window exit
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_ok_d  = 1'b1;
    p1_d     = p1_q;
    xfer     = 1'b0;
    if (dl_rise) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m1_fall && tape_ready_q && (addr == trap)) begin
            state_d  = StLoad;
            rd_ptr_d = '0;
            rd_ok_d  = 1'b0;
            p1_d     = OpNop;
          end
        end
        StLoad: begin
          if (m1_fall && out_of_window) begin
            state_d = StIdle;
          end else if (ce_cpu_p) begin
            if (rd_ptr_q == tape_len_q) begin
              p1_d    = OpScf;
              state_d = StDone;
            end else if (rd_ok_q) begin
              // rd_ok_q guarantees the buffer output reflects the current pointer
              xfer     = 1'b1;
              rd_ptr_d = rd_ptr_q + 1'b1;
              rd_ok_d  = 1'b0;
            end
          end
        end
        StDone: begin
          if (m1_fall && out_of_window) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Register the RAM write for exactly one cycle after each transfer
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ram_we_q  <= 1'b0;
      ram_a_q   <= '0;
      ram_din_q <= '0;
    end else begin
      ram_we_q <= xfer;
      if (xfer) begin
        ram_a_q   <= base_q + 16'(rd_ptr_q);
        ram_din_q <= buf_rdata;
      end
    end
  end

`ifdef ZX_TAPE_CHECKSUM_EN
  logic [7:0] sum_q;

  // Running sum of transferred bytes, restarted on every trap entry
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state_q == StIdle && state_d == StLoad) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + buf_rdata;
    end
  end

  assign tape_sum = sum_q;
`endif

  // Reset masks a pending write in the same cycle
  assign ram.ram_a   = ram_a_q;
  assign ram.ram_din = ram_din_q;
  assign ram.ram_we  = ram_we_q & ~reset;

  assign active     = state_q != StIdle;
  assign tape_ready = tape_ready_q;
  assign patch_dout = patch_byte(addr - trap, p1_q, zx81);

endmodule

// File: tb/tb_zx_tape_loader.sv
// Scoreboard bench for zx_tape_loader: stimulus pushes expected RAM writes,
// a monitor pops and compares on every ram_we. Built with ADDR_W = 4.
module tb_zx_tape_loader;

  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        zx81 = 1'b1;
  logic        dl = 1'b0;
  logic        wr = 1'b0;
  logic [24:0] ioa = '0;
  logic [7:0]  iod = '0;
  logic [7:0]  ioi = '0;
  logic [15:0] addr = 16'h0000;
  logic        nm1 = 1'b1;
  logic [7:0]  patch_dout;
  logic        active;
  logic        tape_ready;
`ifdef ZX_TAPE_CHECKSUM_EN
  logic [7:0]  tape_sum;
`endif

  zx_tape_loader_if ram_bus ();

  zx_tape_loader #(
    .ADDR_W (AW)
  ) dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ce_cpu_p       (ce),
    .zx81           (zx81),
    .ioctl_download (dl),
    .ioctl_wr       (wr),
    .ioctl_addr     (ioa),
    .ioctl_dout     (iod),
    .ioctl_index    (ioi),
    .addr           (addr),
    .nM1            (nm1),
    .ram            (ram_bus),
    .patch_dout     (patch_dout),
    .active         (active),
    .tape_ready     (tape_ready)
`ifdef ZX_TAPE_CHECKSUM_EN
    ,
    .tape_sum       (tape_sum)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;
  logic [7:0]  img[$];
  logic        found;

  // CPU enable: one cycle in four
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
    end
  end

  // Monitor: every RAM write must match the head of the scoreboard
  always @(negedge clk) begin
    if (ram_bus.ram_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got %h@%h, required no write",
                 ram_bus.ram_din, ram_bus.ram_a);
      end else begin
        exp_e = exp_q.pop_front();
        if ({ram_bus.ram_a, ram_bus.ram_din} !== exp_e) begin
          miscompares++;
          $display("FAIL ram_write: got %h@%h, required %h@%h",
                   ram_bus.ram_din, ram_bus.ram_a, exp_e[7:0], exp_e[23:8]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic download(input logic [7:0] idx);
    @(negedge clk);
    dl  = 1'b1;
    ioi = idx;
    @(negedge clk);
    check("ready_cleared_in_download", 16'(tape_ready), 16'd0);
    for (int i = 0; i < img.size(); i++) begin
      ioa = 25'(i);
      iod = img[i];
      wr  = 1'b1;
      @(negedge clk);
      wr  = 1'b0;
      @(negedge clk);
    end
    dl = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic expect_seq(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({base + 16'(i), img[i]});
    end
  endtask

  task automatic m1_fetch(input logic [15:0] a);
    @(negedge clk);
    addr = a;
    nm1  = 1'b0;
    @(negedge clk);
    nm1  = 1'b1;
    @(negedge clk);
  endtask

  task automatic peek(input string name, input logic [15:0] a, input logic [7:0] want);
    @(negedge clk);
    addr = a;
    #1;
    check(name, 16'(patch_dout), 16'(want));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 16'(exp_q.size()), 16'd0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("we_in_reset", 16'(ram_bus.ram_we), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_active", 16'(active), 16'd0);
    check("reset_ready", 16'(tape_ready), 16'd0);
    peek("reset_p1", 16'h0348, 8'h00);
    peek("patch_off0", 16'h0347, 8'hAF);

    // .p image, ZX81
    img = '{8'h11, 8'h22, 8'h33};
    download(8'h40);
    check("p_ready", 16'(tape_ready), 16'd1);
    expect_seq(16'h4009, 3);
    m1_fetch(16'h0347);
    check("p_active", 16'(active), 16'd1);
    wait_drain("p_drain");
    peek("p_scf", 16'h0348, 8'h37);
    peek("p_lo81", 16'h034C, 8'h07);
    peek("p_hi", 16'h034D, 8'h02);
    peek("p_beyond", 16'h034E, 8'hFF);

    // Inside the window stays active, window end exits, trap re-enters from zero
    m1_fetch(16'h03C2);
    check("done_in_window", 16'(active), 16'd1);
    m1_fetch(16'h03C3);
    check("done_exit_end", 16'(active), 16'd0);
    expect_seq(16'h4009, 3);
    m1_fetch(16'h0347);
    check("reenter_active", 16'(active), 16'd1);
    peek("reenter_p1_nop", 16'h0348, 8'h00);
    wait_drain("reenter_drain");
    m1_fetch(16'h0000);
    check("exit_below", 16'(active), 16'd0);

    // .o image, ZX80
    zx81 = 1'b0;
    download(8'h01);
    expect_seq(16'h4000, 3);
    m1_fetch(16'h0207);
    check("o_active", 16'(active), 16'd1);
    wait_drain("o_drain");
    peek("o_lo80", 16'h020C, 8'h03);
    peek("o_scf", 16'h0208, 8'h37);
    peek("o_below", 16'h0206, 8'hFF);
    m1_fetch(16'h024C);
    check("o_in_window", 16'(active), 16'd1);
    m1_fetch(16'h024D);
    check("o_exit_end", 16'(active), 16'd0);

    // Reset after the first byte aborts the copy
    zx81 = 1'b1;
    exp_q.push_back({16'h4000, 8'h11});
    found = 1'b0;
    @(negedge clk);
    addr = 16'h0347;
    nm1  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      nm1 = 1'b1;
      if (ram_bus.ram_we === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    #1 reset = 1'b1;
    check("abort_first_write", 16'(found), 16'd1);
    @(negedge clk);
    check("abort_we_in_reset", 16'(ram_bus.ram_we), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 16'(tape_ready), 16'd0);
    check("abort_active", 16'(active), 16'd0);
    repeat (40) @(negedge clk);
    check("abort_queue", 16'(exp_q.size()), 16'd0);

    // 20-byte download into a 16-byte buffer
    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'(i + 1));
    download(8'h40);
    check("big_ready", 16'(tape_ready), 16'd1);
    expect_seq(16'h4009, 16);
    m1_fetch(16'h0347);
    wait_drain("big_drain");
    peek("big_scf", 16'h0348, 8'h37);
    m1_fetch(16'h0000);
    check("big_exit", 16'(active), 16'd0);

`ifdef ZX_TAPE_CHECKSUM_EN
    img = '{8'hFF, 8'h02};
    download(8'h40);
    expect_seq(16'h4009, 2);
    m1_fetch(16'h0347);
    wait_drain("sum_drain");
    check("tape_sum", 16'(tape_sum), 16'h0001);
    m1_fetch(16'h0000);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
